// File: rtl/pixel_streamer.sv
// -----------------------------------------------------------------------------
// pixel_streamer
//
// Reads a W x H frame from a linear source memory (addresses 0 .. W*H-1).
// The pixels come out as a valid/ready beat stream with their (x, y)
// coordinates and first/last-of-frame markers.
//
// Read data comes back one cycle after mem_rd. Each returned byte is pushed
// into a 2-entry output FIFO together with the coordinates and flags that were
// captured when the read was issued. The FIFO head registers drive the beat
// outputs directly, so the head cannot change while a beat is stalled.
//
// Optional feature (compile-time macro):
//   PIXEL_STREAMER_CONTINUOUS_EN
//     If start is high when the last read of a frame issues, the address wraps
//     to 0. The block stays in RUN and begins the next frame with the same
//     W/H, leaving no gap between frames. When the macro is undefined, every
//     frame ends through DRAIN back to IDLE.
//
// Ports:
//   clk_os         single clock, rising edge
//   reset_os       asynchronous active-low reset
//   start          frame start request (acted on in IDLE only)
//   frame_width    frame width in pixels  (latched on accepted start)
//   frame_height   frame height in lines  (latched on accepted start)
//   mem_rd         source memory read strobe
//   mem_addr       linear source read address
//   mem_data       source read data, valid the cycle after mem_rd
//   o_pixel        streamed pixel
//   o_xcoord       x coordinate of o_pixel
//   o_ycoord       y coordinate of o_pixel
//   o_valid        current beat is valid
//   i_ready        downstream accepts the beat (transfer = o_valid & i_ready)
//   o_frame_start  beat is pixel (0,0)
//   o_frame_end    beat is pixel (W-1,H-1)
//   o_busy         block is not in IDLE
// -----------------------------------------------------------------------------
module pixel_streamer #(
    parameter int DATA_WIDTH_8  = 8,
    parameter int DATA_WIDTH_12 = 12,
    parameter int ADDR_WIDTH    = 20
) (
    input  logic                     clk_os,
    input  logic                     reset_os,
    input  logic                     start,
    input  logic [DATA_WIDTH_12-1:0] frame_width,
    input  logic [DATA_WIDTH_12-1:0] frame_height,
    output logic                     mem_rd,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    input  logic [DATA_WIDTH_8-1:0]  mem_data,
    output logic [DATA_WIDTH_8-1:0]  o_pixel,
    output logic [DATA_WIDTH_12-1:0] o_xcoord,
    output logic [DATA_WIDTH_12-1:0] o_ycoord,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_frame_start,
    output logic                     o_frame_end,
    output logic                     o_busy
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // A FIFO entry is {pixel, x, y, frame_start, frame_end}.
    localparam int META_W  = 2 * DATA_WIDTH_12 + 2;
    localparam int ENTRY_W = DATA_WIDTH_8 + META_W;
    localparam int FE_BIT  = 0;
    localparam int FS_BIT  = 1;
    localparam int Y_LSB   = 2;
    localparam int X_LSB   = 2 + DATA_WIDTH_12;
    localparam int PIX_LSB = META_W;

    localparam logic [DATA_WIDTH_12-1:0] DIM_ZERO  = {DATA_WIDTH_12{1'b0}};
    localparam logic [DATA_WIDTH_12-1:0] DIM_ONE   = {{(DATA_WIDTH_12-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ENTRY_W-1:0]       ENTRY_ZERO = {ENTRY_W{1'b0}};
    localparam logic [META_W-1:0]        META_ZERO  = {META_W{1'b0}};

    // State and frame geometry
    logic [1:0]               state_r;
    logic [1:0]               state_nxt_s;
    logic [DATA_WIDTH_12-1:0] w_last_r;     // W-1, latched on start
    logic [DATA_WIDTH_12-1:0] h_last_r;     // H-1, latched on start

    // Read-issue side: address and coordinates of the next read
    logic [ADDR_WIDTH-1:0]    addr_r;
    logic [DATA_WIDTH_12-1:0] rd_x_r;
    logic [DATA_WIDTH_12-1:0] rd_y_r;

    // Read in flight: its data arrives on mem_data in the current cycle
    logic                     pend_r;
    logic [META_W-1:0]        pend_meta_r;

    // 2-entry output FIFO: head_r is the visible beat, tail_r the second slot
    logic [ENTRY_W-1:0]       head_r;
    logic [ENTRY_W-1:0]       tail_r;
    logic [1:0]               cnt_r;
    logic                     valid_r;

    // Combinational control
    logic                     accept_s;
    logic                     pop_s;
    logic                     push_s;
    logic [1:0]               occ_s;
    logic                     rd_s;
    logic                     last_rd_s;
    logic                     first_rd_s;
    logic                     wrap_s;
    logic [1:0]               cnt_nxt_s;
    logic [ENTRY_W-1:0]       push_entry_s;

    assign accept_s = (state_r == ST_IDLE) && start &&
                      (frame_width != DIM_ZERO) && (frame_height != DIM_ZERO);

    assign pop_s  = valid_r & i_ready;
    assign push_s = pend_r;

    // Occupancy counts the FIFO after this cycle's pop, plus the read whose
    // data lands this cycle. A new read is allowed only if its data is sure
    // to find a free slot even if downstream stalls from now on. Crediting
    // the pop in the same cycle is what allows one read per cycle.
    assign occ_s = cnt_r - {1'b0, pop_s} + {1'b0, pend_r};
    assign rd_s  = (state_r == ST_RUN) && (occ_s < 2'd2);

    assign last_rd_s  = (rd_x_r == w_last_r) && (rd_y_r == h_last_r);
    assign first_rd_s = (rd_x_r == DIM_ZERO) && (rd_y_r == DIM_ZERO);

`ifdef PIXEL_STREAMER_CONTINUOUS_EN
    assign wrap_s = rd_s && last_rd_s && start;
`else
    assign wrap_s = 1'b0;
`endif

    assign cnt_nxt_s    = cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    assign push_entry_s = {mem_data, pend_meta_r};

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rd_s && last_rd_s) begin
                    if (wrap_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // No reads are issued in DRAIN. A zero projected count
                // therefore also means no data is still on its way.
                if (cnt_nxt_s == 2'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame geometry latch plus the read address and coordinate counters.
    // x wraps at W-1 and carries into y, so no multiplier is needed.
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            w_last_r <= DIM_ZERO;
            h_last_r <= DIM_ZERO;
            addr_r   <= ADDR_ZERO;
            rd_x_r   <= DIM_ZERO;
            rd_y_r   <= DIM_ZERO;
        end else if (accept_s) begin
            w_last_r <= frame_width - DIM_ONE;
            h_last_r <= frame_height - DIM_ONE;
            addr_r   <= ADDR_ZERO;
            rd_x_r   <= DIM_ZERO;
            rd_y_r   <= DIM_ZERO;
        end else if (rd_s) begin
            if (wrap_s) begin
                addr_r <= ADDR_ZERO;
            end else begin
                addr_r <= addr_r + ADDR_ONE;
            end
            if (rd_x_r == w_last_r) begin
                rd_x_r <= DIM_ZERO;
                if (rd_y_r == h_last_r) begin
                    rd_y_r <= DIM_ZERO;
                end else begin
                    rd_y_r <= rd_y_r + DIM_ONE;
                end
            end else begin
                rd_x_r <= rd_x_r + DIM_ONE;
            end
        end
    end

    // In-flight tracking: carry each read's coordinates and flags forward
    // one cycle to meet its returning data. Reset drops any read in flight.
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            pend_r      <= 1'b0;
            pend_meta_r <= META_ZERO;
        end else begin
            pend_r <= rd_s;
            if (rd_s) begin
                pend_meta_r <= {rd_x_r, rd_y_r, first_rd_s, last_rd_s};
            end
        end
    end

    // Output FIFO. The head only changes on a pop, or on a push into an
    // empty FIFO, so a stalled beat stays stable.
    always_ff @(posedge clk_os or negedge reset_os) begin
        if (!reset_os) begin
            head_r  <= ENTRY_ZERO;
            tail_r  <= ENTRY_ZERO;
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        head_r <= push_entry_s;
                    end else begin
                        tail_r <= push_entry_s;
                    end
                end
                2'b01: begin
                    if (cnt_r == 2'd2) begin
                        head_r <= tail_r;
                    end
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        head_r <= push_entry_s;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= push_entry_s;
                    end
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
            cnt_r   <= cnt_nxt_s;
            valid_r <= (cnt_nxt_s != 2'd0);
        end
    end

    assign mem_rd        = rd_s;
    assign mem_addr      = addr_r;
    assign o_pixel       = head_r[PIX_LSB +: DATA_WIDTH_8];
    assign o_xcoord      = head_r[X_LSB +: DATA_WIDTH_12];
    assign o_ycoord      = head_r[Y_LSB +: DATA_WIDTH_12];
    assign o_frame_start = head_r[FS_BIT];
    assign o_frame_end   = head_r[FE_BIT];
    assign o_valid       = valid_r;
    assign o_busy        = (state_r != ST_IDLE);

endmodule
